// File: rtl/sram_loader.sv
// sram_loader: write-side front end of the SRAM summing path.
// Streams words into SRAM from address 0, then hands off to the reader.
`timescale 1ns/1ps

module sram_loader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              clear,
    input  logic              sum_busy,
    output logic              SRAM_we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] top_addr,
    output logic [ADDR_W:0]   word_cnt,
    output logic              start_sum,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HANDOFF,
        WAIT_START,
        WAIT_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   ptr_nxt;
    logic [ADDR_W-1:0]   base_ptr;
    logic [ADDR_W:0]     base_cnt;
    logic [ADDR_W:0]     cnt_inc;
    logic [ADDR_W:0]     cnt_nxt;
    logic                accept;
    logic                last_beat;
    logic                we_nxt;
    logic [ADDR_W-1:0]   waddr_nxt;
    logic [DATA_W-1:0]   din_nxt;
    logic [ADDR_W-1:0]   top_nxt;
    logic                start_nxt;
    logic                done_nxt;

    // Next-state, handshake and next register values for the load FSM.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = word_cnt;
        we_nxt    = 1'b0;
        waddr_nxt = waddr;
        din_nxt   = din;
        top_nxt   = top_addr;
        start_nxt = 1'b0;
        done_nxt  = 1'b0;
        in_ready  = 1'b0;

        unique case (state)
            IDLE:    in_ready = 1'b1;
            LOAD:    in_ready = (word_cnt < DEPTH_CNT);
            default: in_ready = 1'b0;
        endcase
        if (clear || rst) begin
            in_ready = 1'b0;
        end

        accept    = in_valid && in_ready;
        base_ptr  = (state == IDLE) ? '0 : ptr;
        base_cnt  = (state == IDLE) ? '0 : word_cnt;
        cnt_inc   = base_cnt + 1'b1;
        last_beat = in_last || (cnt_inc == DEPTH_CNT);

        if (accept) begin
            we_nxt    = 1'b1;
            waddr_nxt = base_ptr;
            din_nxt   = in_data;
            cnt_nxt   = cnt_inc;
            // Hold the pointer on the final beat so it never overflows.
            ptr_nxt   = last_beat ? base_ptr : base_ptr + 1'b1;
            state_nxt = last_beat ? HANDOFF : LOAD;
        end

        unique case (state)
            LOAD: begin
                if (clear) begin
                    state_nxt = IDLE;
                end
            end
            HANDOFF: begin
                top_nxt   = word_cnt[ADDR_W-1:0] - 1'b1;
                start_nxt = 1'b1;
                state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (sum_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!sum_busy) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered SRAM write port, counters and handoff strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            word_cnt  <= '0;
            SRAM_we   <= 1'b0;
            waddr     <= '0;
            din       <= '0;
            top_addr  <= '0;
            start_sum <= 1'b0;
            done      <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            word_cnt  <= cnt_nxt;
            SRAM_we   <= we_nxt;
            waddr     <= waddr_nxt;
            din       <= din_nxt;
            top_addr  <= top_nxt;
            start_sum <= start_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_sram_loader.sv
// tb_sram_loader: directed bench for sram_loader.
// Expected writes/handoffs/done pulses are queued and checked by a monitor.
`timescale 1ns/1ps

module tb_sram_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        clear = 1'b0;
    logic        sum_busy = 1'b0;
    logic        SRAM_we;
    logic [8:0]  waddr;
    logic [31:0] din;
    logic [8:0]  top_addr;
    logic [9:0]  word_cnt;
    logic        start_sum;
    logic        done;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
        longint      t;
    } wr_t;

    typedef struct {
        logic [8:0] top;
        logic [9:0] cnt;
        longint     t;
    } st_t;

    wr_t    wq[$];
    st_t    sq[$];
    longint dq[$];
    wr_t    mw;
    st_t    ms;
    longint md;
    int     tests = 0;
    int     fails = 0;
    logic [8:0] exp_addr = '0;
    longint t_acc;

    sram_loader #(
        .ADDR_W(9),
        .DATA_W(32),
        .DEPTH(512)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .in_ready(in_ready),
        .clear(clear),
        .sum_busy(sum_busy),
        .SRAM_we(SRAM_we),
        .waddr(waddr),
        .din(din),
        .top_addr(top_addr),
        .word_cnt(word_cnt),
        .start_sum(start_sum),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"}, 64'(SRAM_we), 0);
        chk({tag, "_waddr"}, 64'(waddr), 0);
        chk({tag, "_din"}, 64'(din), 0);
        chk({tag, "_top"}, 64'(top_addr), 0);
        chk({tag, "_cnt"}, 64'(word_cnt), 0);
        chk({tag, "_start"}, 64'(start_sum), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_ready"}, 64'(in_ready), 0);
    endtask

    // Monitor: every DUT event must match the head of its queue.
    always @(negedge clk) begin
        if (SRAM_we === 1'b1) begin
            if (wq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, required no write",
                         waddr, din);
            end else begin
                mw = wq.pop_front();
                chk("wr_addr", 64'(waddr), 64'(mw.addr));
                chk("wr_data", 64'(din), 64'(mw.data));
                chk("wr_time", 64'($time), 64'(mw.t));
            end
        end
        if (start_sum === 1'b1) begin
            if (sq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_start: got start_sum at %0t, required none", $time);
            end else begin
                ms = sq.pop_front();
                chk("start_top", 64'(top_addr), 64'(ms.top));
                chk("start_cnt", 64'(word_cnt), 64'(ms.cnt));
                chk("start_time", 64'($time), 64'(ms.t));
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done at %0t, required none", $time);
            end else begin
                md = dq.pop_front();
                chk("done_time", 64'($time), 64'(md));
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic last,
                             output longint t);
        logic r;
        bit ok;
        ok = 1'b0;
        t = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            t = longint'($time);
            wq.push_back('{exp_addr, d, t + 5});
            exp_addr++;
        end else begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: data 0x%0h not accepted, required acceptance", d);
        end
        #1;
    endtask

    task automatic burst(input int n, input bit use_last, input bit gaps,
                         input logic [31:0] base, input logic [31:0] step,
                         input int hold);
        longint t;
        t = 0;
        exp_addr = '0;
        for (int i = 0; i < n; i++) begin
            send_word(base + step * i, use_last && (i == n - 1), t);
            if (gaps && i != n - 1) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = (hold > 0);
        in_last = 1'b0;
        in_data = 32'hBAD0_0000;
        sq.push_back('{9'(n - 1), 10'(n), t + 15});
        for (int k = 0; k < ((hold > 0) ? hold : 1); k++) begin
            @(negedge clk);
            chk("ready_low_after_last", 64'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic reader();
        repeat (3) @(posedge clk);
        #1 sum_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 sum_busy = 1'b0;
        dq.push_back(longint'($time) + 14);
        repeat (3) @(posedge clk);
        #1;
        chk("ready_after_done", 64'(in_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_idle", 64'(in_ready), 1);
        @(posedge clk);
        #1;

        burst(4, 1'b1, 1'b0, 32'h11, 32'h11, 0);
        reader();

        burst(3, 1'b1, 1'b1, 32'hA1, 32'h1, 0);
        reader();

        burst(1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 3);
        reader();

        exp_addr = '0;
        for (int i = 0; i < 5; i++) begin
            send_word(32'h50 + i, 1'b0, t_acc);
        end
        clear = 1'b1;
        in_data = 32'h5555_5555;
        @(negedge clk);
        chk("clear_blocks_ready", 64'(in_ready), 0);
        @(posedge clk);
        #1 clear = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("clear_cnt", 64'(word_cnt), 5);
        chk("clear_idle_ready", 64'(in_ready), 1);
        @(posedge clk);
        #1;
        burst(2, 1'b1, 1'b0, 32'h60, 32'h1, 0);
        reader();

        burst(512, 1'b0, 1'b0, 32'h1000_0000, 32'h1, 2);
        reader();

        exp_addr = '0;
        for (int i = 0; i < 3; i++) begin
            send_word(32'h70 + i, 1'b0, t_acc);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready_low", 64'(in_ready), 0);
        @(negedge clk);
        chk_reset("rst_load");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_load_release_ready", 64'(in_ready), 1);
        @(posedge clk);
        #1;

        burst(2, 1'b1, 1'b0, 32'h80, 32'h1, 0);
        repeat (3) @(posedge clk);
        #1 sum_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        sum_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset("rst_wait_done");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_done_release_ready", 64'(in_ready), 1);
        repeat (5) @(posedge clk);

        @(negedge clk);
        chk("writes_pending", 64'(wq.size()), 0);
        chk("starts_pending", 64'(sq.size()), 0);
        chk("dones_pending", 64'(dq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_loader.md
Name: sram_loader

Overview:
- Write-side front end for the SRAM summing path: accepts a valid/ready word stream and writes the words to consecutive SRAM addresses starting at 0.
- When the burst ends, hands off to the read/accumulate side. It pulses a start strobe and presents the top address from which the reader counts down to zero.
- It holds off new input until the reader reports it has finished.

Parameters:
- ADDR_W, 9, SRAM address width.
- DATA_W, 32, data word width.
- DEPTH, 512, number of SRAM words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_data  input  DATA_W  input word.
- in_last  input  1  marks the final word of a burst; qualified by in_valid.
- in_ready  output  1  loader can accept a word this cycle.
- clear  input  1  abort the current load and return to IDLE without handoff.
- sum_busy  input  1  read/accumulate side is busy.
- SRAM_we  output  1  SRAM write enable; registered.
- waddr  output  ADDR_W  SRAM write address; registered.
- din  output  DATA_W  SRAM write data; registered.
- top_addr  output  ADDR_W  highest written address; valid from the start pulse until the next load begins.
- word_cnt  output  ADDR_W+1  number of words written in the current or last burst.
- start_sum  output  1  one-cycle pulse launching the reader.
- done  output  1  one-cycle pulse when the reader has finished.

Behaviour:
- Reset values:
  - SRAM_we=0, waddr=0, din=0, top_addr=0, word_cnt=0, start_sum=0, done=0, in_ready=0.
  - State=IDLE.
- Beat acceptance: a beat is accepted when in_valid and in_ready are both 1 at a rising edge.
- States: IDLE, LOAD, HANDOFF, WAIT_START, WAIT_DONE.
- IDLE:
  - in_ready=1.
  - The first accepted beat moves to LOAD.
  - word_cnt is cleared to 0 before counting that beat.
  - The write pointer restarts at 0.
- LOAD:
  - in_ready=1 while word_cnt < DEPTH.
  - Each accepted beat causes, on the following cycle: SRAM_we=1, waddr=ptr, din=in_data. Write latency is 1 cycle.
  - After the beat, ptr increments and word_cnt increments.
  - SRAM_we=0 in any cycle with no accepted beat on the previous edge.
- Leaving LOAD:
  - Exit condition: an accepted beat with in_last=1, or an accepted beat that brings word_cnt to DEPTH (an implicit last).
  - in_ready drops to 0 on the following cycle and the state moves to HANDOFF.
  - Further in_valid is ignored; no data is dropped because in_ready is 0.
- HANDOFF:
  - Lasts one cycle; it coincides with the final write (SRAM_we=1).
  - top_addr = word_cnt-1.
  - Next cycle: start_sum=1 for exactly one cycle, then go to WAIT_START.
  - The final write therefore completes before start_sum is seen.
- WAIT_START: wait for sum_busy=1, then go to WAIT_DONE. There is no timeout.
- WAIT_DONE: on the first cycle sum_busy=0, pulse done for 1 cycle and return to IDLE.
- in_ready=0 in HANDOFF, WAIT_START and WAIT_DONE.
- clear:
  - In LOAD, clear=1 returns to IDLE next cycle with no start_sum.
  - A write already registered from the previous edge still completes.
  - word_cnt holds the partial count.
  - A beat presented in the same cycle as clear is not accepted; in_ready is forced to 0 when clear=1.
  - clear is ignored in HANDOFF, WAIT_START and WAIT_DONE.
- Simultaneous events:
  - in_last together with the DEPTH-th word is a single termination.
  - rst has priority over clear and all other inputs.
- Reset mid-operation:
  - Next edge forces SRAM_we=0 and state IDLE.
  - A pending start_sum or done pulse is suppressed.
- Width rules:
  - word_cnt is ADDR_W+1 bits so that DEPTH is representable.
  - ptr wraps only through the restart at IDLE, never by overflow.

Test Plan:
- 4-word burst (0x11,0x22,0x33,0x44, last on 4th) with in_valid held high:
  - Writes at addr 0..3 on consecutive cycles, each one cycle after acceptance.
  - top_addr=3, word_cnt=4.
  - start_sum one cycle after the final write.
  - With sum_busy high for 10 cycles then low: done pulses once and in_ready returns to 1.
- 512 words, in_last never asserted:
  - Last write at addr 511.
  - in_ready=0 from the cycle after the 512th acceptance.
  - top_addr=511, word_cnt=512, exactly one start_sum.
- in_valid toggling 1,0,1,0 for 3 words, last on 3rd:
  - SRAM_we high only on cycles following accepted beats.
  - Addresses 0,1,2 with no gaps in address sequence; top_addr=2.
- clear asserted after 5 accepted words:
  - No start_sum.
  - The 5th write still occurs at addr 4.
  - word_cnt=5, state IDLE.
  - Next burst writes starting at addr 0.
- rst asserted mid-LOAD and again during WAIT_DONE:
  - Next cycle: SRAM_we=0, in_ready=0, outputs at reset values.
  - No done pulse.
  - After rst drops, in_ready=1.
- Single-word burst (in_last on first beat, data 0xDEADBEEF):
  - Write at addr 0, top_addr=0, word_cnt=1.
  - in_valid held high during WAIT_START is not accepted: no SRAM_we is generated.
